// File: rtl/div_seq_if.sv
// Handshake and datapath bundle between the divider, its operand source and
// the downstream mask-OR stage.
interface div_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] q_or_i;
    logic [W-1:0] mask_o;
    logic [W-1:0] q_acc_o;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         err_div0;

    modport slave (
        input  start, dividend, divisor, q_or_i,
        output mask_o, q_acc_o, quotient, remainder, busy, done, err_div0
    );

    modport master (
        output start, dividend, divisor, q_or_i,
        input  mask_o, q_acc_o, quotient, remainder, busy, done, err_div0
    );
endinterface

// File: rtl/div_seq.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first. Quotient
// bits are set by an external mask-OR stage fed back through q_or_i.
module div_seq #(
    parameter int W = 16
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  mask_q, mask_d;
    logic [W-1:0]  qacc_q, qacc_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rout_q, rout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [W:0]    r_sh;
    logic [W-1:0]  r_sub;
    logic          take;

    // Compare on W+1 bits; when the subtraction is taken the true difference is
    // below the divisor, so the low W bits of the wrapped result are exact.
    always_comb begin
        r_sh  = {rem_q, dvd_q[cnt_q]};
        take  = (r_sh >= {1'b0, dvs_q});
        r_sub = r_sh[W-1:0] - dvs_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            mask_q  <= '0;
            qacc_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rout_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            mask_q  <= mask_d;
            qacc_q  <= qacc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rout_q  <= rout_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        mask_d  = mask_q;
        qacc_d  = qacc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rout_d  = rout_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    mask_d  = '0;
                    qacc_d  = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    rout_d  = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (dvs_q == '0) begin
                    quo_d   = '1;
                    rout_d  = dvd_q;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    mask_d  = {1'b1, {(W-1){1'b0}}};
                    cnt_d   = CW'(W - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d  = take ? r_sub : r_sh[W-1:0];
                qacc_d = take ? bus.q_or_i : qacc_q;
                mask_d = mask_q >> 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quo_d   = qacc_d;
                    rout_d  = rem_d;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mask_o    = (state_q == CALC) ? mask_q : '0;
    assign bus.q_acc_o   = qacc_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rout_q;
    assign bus.busy      = (state_q == LOAD) || (state_q == CALC);
    assign bus.done      = (state_q == DONE);
    assign bus.err_div0  = err_q;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: vector table plus hand sequences for mask walk, busy
// protection and mid-operation reset; results checked through a scoreboard.
module tb_div_seq;
    localparam int W  = 16;
    localparam int NV = 7;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_seq_if #(.W(W)) bus ();
    assign bus.q_or_i = bus.q_acc_o | bus.mask_o;

    div_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_pass = 0;
    int   n_total = 0;
    int   done_cnt = 0;
    res_t sb[$];
    vec_t vecs[NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    function automatic res_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic err);
        res_t e;
        e.q = q; e.r = r; e.err = err;
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest accepted start.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.done === 1'b1) begin
            res_t e;
            done_cnt++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("quotient",  32'(bus.quotient),  32'(e.q));
                check("remainder", 32'(bus.remainder), 32'(e.r));
                check("err_div0",  32'(bus.err_div0),  32'(e.err));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit track, input res_t e);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        if (track) sb.push_back(e);
        #1;
        bus.start    = 1'b0;
        bus.dividend = '1;
        bus.divisor  = '1;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_mask"},  32'(bus.mask_o),    32'd0);
        check({nm, "_qacc"},  32'(bus.q_acc_o),   32'd0);
        check({nm, "_quot"},  32'(bus.quotient),  32'd0);
        check({nm, "_rem"},   32'(bus.remainder), 32'd0);
        check({nm, "_flags"}, 32'({bus.busy, bus.done, bus.err_div0}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            d0;
        logic [W-1:0]  m;

        vecs[0] = '{a: 16'd100,    b: 16'd7,      q: 16'd14,     r: 16'd2,      err: 1'b0, lat: 18};
        vecs[1] = '{a: 16'hFFFF,   b: 16'h0001,   q: 16'hFFFF,   r: 16'h0000,   err: 1'b0, lat: 18};
        vecs[2] = '{a: 16'h0005,   b: 16'h000A,   q: 16'h0000,   r: 16'h0005,   err: 1'b0, lat: 18};
        vecs[3] = '{a: 16'h1234,   b: 16'h0000,   q: 16'hFFFF,   r: 16'h1234,   err: 1'b1, lat: 2};
        vecs[4] = '{a: 16'd9,      b: 16'd3,      q: 16'd3,      r: 16'd0,      err: 1'b0, lat: 18};
        vecs[5] = '{a: 16'hFFFF,   b: 16'hFFFF,   q: 16'h0001,   r: 16'h0000,   err: 1'b0, lat: 18};
        vecs[6] = '{a: 16'hFFFE,   b: 16'h8000,   q: 16'h0001,   r: 16'h7FFE,   err: 1'b0, lat: 18};

        rst = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].a, vecs[i].b, 1'b1, mk(vecs[i].q, vecs[i].r, vecs[i].err));
            wait_done(lat);
            check("latency", 32'(lat), 32'(vecs[i].lat));
            @(posedge clk);
            #1;
            check("done_one_cycle", 32'({bus.done, bus.busy}), 32'd0);
        end

        // Mask walk: one bit per CALC cycle, single quotient bit at the MSB.
        start_op(16'h8000, 16'h0001, 1'b1, mk(16'h8000, 16'h0000, 1'b0));
        @(posedge clk);
        #1;
        m = 16'h8000;
        for (int i = 0; i < W; i++) begin
            check("mask_walk", 32'(bus.mask_o), 32'(m));
            m = m >> 1;
            @(posedge clk);
            #1;
        end
        check("mask_walk_done", 32'(bus.done), 32'd1);
        check("mask_walk_qacc", 32'(bus.q_acc_o), 32'h8000);
        check("mask_after_calc", 32'(bus.mask_o), 32'd0);
        @(posedge clk);

        // A start while busy must be dropped, not queued.
        start_op(16'd100, 16'd7, 1'b1, mk(16'd14, 16'd2, 1'b0));
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor = 16'd5;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("busy_prot_done", 32'(bus.done), 32'd1);
        repeat (25) @(posedge clk);
        check("busy_prot_single_done", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of CALC aborts with no done pulse.
        d0 = done_cnt;
        start_op(16'd1000, 16'd3, 1'b0, mk(16'd0, 16'd0, 1'b0));
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("midop_reset");
        @(negedge clk);
        rst = 1'b1;
        start_op(16'd81, 16'd9, 1'b1, mk(16'd9, 16'd0, 1'b0));
        wait_done(lat);
        check("post_reset_latency", 32'(lat), 32'd18);
        @(posedge clk);
        @(negedge clk);
        check("midop_no_extra_done", 32'(done_cnt - d0), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
